// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg: shared types and constants for alu_result_serializer.
// ALU_SER_CHECKSUM_EN lengthens the frame by one XOR checksum byte.
package alu_ser_pkg;
  typedef enum logic {IDLE, SEND} state_t;
`ifdef ALU_SER_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_ser_fifo.sv
// alu_ser_fifo: DEPTH x W synchronous FIFO with occupancy count; caller never pushes when full
// or pops when empty.
module alu_ser_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results+flags and streams each as an acked byte frame.
// ALU_SER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] HDR_NIBBLE = 4'hA
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [3:0]               in_flags,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     overrun
);
  state_t state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [35:0] head, frame, frame_d;
  logic [7:0] bytes [FRAME_LEN];
  logic push, pop, full, empty;
  // rst_n term keeps in_ready low while reset is held
  assign in_ready = rst_n & ena & ~full;
  assign push = in_valid & in_ready;
  alu_ser_fifo #(.DEPTH(DEPTH), .W(36)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata({in_flags, in_result}),
    .rdata(head), .count(fifo_count), .full(full), .empty(empty)
  );
  assign bytes[0] = {HDR_NIBBLE, frame[32+FLAG_Z], frame[32+FLAG_N], frame[32+FLAG_C], frame[32+FLAG_V]};
  for (genvar i = 0; i < 4; i++) begin : g_res
    assign bytes[i+1] = frame[8*i +: 8];
  end
`ifdef ALU_SER_CHECKSUM_EN
  assign bytes[5] = bytes[0] ^ bytes[1] ^ bytes[2] ^ bytes[3] ^ bytes[4];
`endif
  assign out_valid = state == SEND;
  assign out_byte = out_valid ? bytes[idx] : '0;
  assign busy = out_valid | (fifo_count != '0);
  always_comb begin
    state_d = state;
    idx_d = idx;
    frame_d = frame;
    pop = 1'b0;
    if (ena && state == IDLE && !empty) begin
      pop = 1'b1;
      frame_d = head;
      idx_d = '0;
      state_d = SEND;
    end else if (ena && state == SEND && out_ack) begin
      state_d = idx == IDX_W'(FRAME_LEN-1) ? IDLE : SEND;
      idx_d = idx == IDX_W'(FRAME_LEN-1) ? idx : idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      frame <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      frame <= frame_d;
      overrun <= overrun | (ena & in_valid & ~in_ready);
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: scoreboard bench; accepted pushes queue expected frame bytes,
// a monitor pops and compares on every acked output byte.
module tb_alu_result_serializer;
`ifdef ALU_SER_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif
  logic clk = 0, rst_n = 0, ena = 1, in_valid = 0, out_ack = 0;
  logic in_ready, out_valid, busy, overrun;
  logic [31:0] in_result = 0;
  logic [3:0] in_flags = 0;
  logic [7:0] out_byte;
  logic [2:0] fifo_count;
  logic auto_ack = 0, man_ack = 0;
  int pass_cnt = 0, tot_cnt = 0;
  logic [7:0] sb [$];
  logic [7:0] fb [6];
  logic [31:0] exp_b;

  always #5 clk = ~clk;

  alu_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .out_byte(out_byte), .out_valid(out_valid),
    .out_ack(out_ack), .fifo_count(fifo_count), .busy(busy), .overrun(overrun)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always begin
    @(posedge clk);
    #2;
    out_ack = auto_ack ? 1'($urandom_range(0, 1)) : man_ack;
  end

  // reference model: an accepted entry becomes header, four result bytes LSB first, optional xor
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else if (in_valid && in_ready) begin
      fb[0] = {4'hA, in_flags};
      for (int i = 0; i < 4; i++) fb[i+1] = in_result[8*i +: 8];
      fb[5] = fb[0] ^ fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
      for (int i = 0; i < FLEN; i++) sb.push_back(fb[i]);
    end
  end

  always @(negedge clk)
    if (rst_n && ena && out_valid && out_ack) begin
      exp_b = sb.size() != 0 ? {24'h0, sb.pop_front()} : 32'hDEAD;
      chk("out_byte", {24'h0, out_byte}, exp_b);
    end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] r, logic [3:0] f);
    in_result = r;
    in_flags = f;
    in_valid = 1;
    cyc();
    in_valid = 0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (busy && n < 300) begin
      cyc();
      n++;
    end
    chk(name, {31'h0, busy}, 0);
    chk({name, "_sb"}, sb.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("valid_wait", {31'h0, out_valid}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2);
    chk("rst_in_ready", {31'h0, in_ready}, 0);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_byte", {24'h0, out_byte}, 0);
    chk("rst_count", {29'h0, fifo_count}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_overrun", {31'h0, overrun}, 0);
    rst_n = 1;
    #1;
    chk("rdy_after_rst", {31'h0, in_ready}, 1);
    cyc();
    // single frame and push-to-valid latency
    push(32'h12345678, 4'b0010);
    chk("lat_k", {31'h0, out_valid}, 0);
    chk("cnt_k", {29'h0, fifo_count}, 1);
    cyc();
    chk("lat_k1", {31'h0, out_valid}, 1);
    chk("hdr_byte", {24'h0, out_byte}, 32'hA2);
    man_ack = 1;
    drain("t1_drain");
    man_ack = 0;
    // simultaneous push and pop at count 2, plus inter-frame gap
    push($urandom, 4'($urandom));
    push($urandom, 4'($urandom));
    push($urandom, 4'($urandom));
    chk("t3_pre", {29'h0, fifo_count}, 2);
    man_ack = 1;
    cyc(FLEN);
    man_ack = 0;
    chk("t3_gap", {31'h0, out_valid}, 0);
    push($urandom, 4'($urandom));
    chk("t3_cnt", {29'h0, fifo_count}, 2);
    man_ack = 1;
    drain("t3_drain");
    // ack while idle is ignored
    cyc(3);
    chk("t6_idle_valid", {31'h0, out_valid}, 0);
    chk("t6_idle_busy", {31'h0, busy}, 0);
    push($urandom, 4'($urandom));
    drain("t6_drain");
    man_ack = 0;
    // enable low freezes everything mid-frame
    push($urandom, 4'($urandom));
    wait_valid();
    man_ack = 1;
    cyc(2);
    man_ack = 0;
    ena = 0;
    man_ack = 1;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_byte", {24'h0, out_byte}, {24'h0, sb[0]});
      chk("t4_valid", {31'h0, out_valid}, 1);
      chk("t4_count", {29'h0, fifo_count}, 0);
      chk("t4_ready", {31'h0, in_ready}, 0);
      chk("t4_overrun", {31'h0, overrun}, 0);
    end
    in_valid = 0;
    ena = 1;
    drain("t4_drain");
    man_ack = 0;
    // fill FIFO without acks, then overflow
    for (int i = 0; i < 5; i++) push($urandom, 4'($urandom));
    chk("t2_full_count", {29'h0, fifo_count}, 4);
    chk("t2_full_ready", {31'h0, in_ready}, 0);
    chk("t2_pre_overrun", {31'h0, overrun}, 0);
    push($urandom, 4'($urandom));
    chk("t2_overrun", {31'h0, overrun}, 1);
    chk("t2_count_kept", {29'h0, fifo_count}, 4);
    man_ack = 1;
    drain("t2_drain");
    chk("t2_sticky", {31'h0, overrun}, 1);
    man_ack = 0;
    // reset mid-frame after third byte acked
    push($urandom, 4'($urandom));
    wait_valid();
    man_ack = 1;
    cyc(3);
    man_ack = 0;
    rst_n = 0;
    #1;
    chk("t5_valid", {31'h0, out_valid}, 0);
    chk("t5_byte", {24'h0, out_byte}, 0);
    chk("t5_busy", {31'h0, busy}, 0);
    chk("t5_overrun", {31'h0, overrun}, 0);
    chk("t5_ready", {31'h0, in_ready}, 0);
    cyc();
    rst_n = 1;
    cyc();
    push($urandom, 4'($urandom));
    man_ack = 1;
    drain("t5_drain");
    chk("t5_overrun_after", {31'h0, overrun}, 0);
    man_ack = 0;
    // random traffic with random acks
    auto_ack = 1;
    for (int i = 0; i < 40; i++)
      if ($urandom_range(0, 2) != 0) push($urandom, 4'($urandom));
      else cyc();
    drain("rand_drain");
    auto_ack = 0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
